// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional even
// parity, one stop bit; bit timing from an internal per-bit clock counter.
module uart_tx #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int PARITY_EN    = 0
) (
   input  logic       clock_IN,
   input  logic       reset_IN,
   input  logic [7:0] data_IN,
   input  logic       valid_IN,
   output logic       ready_OUT,
   output logic       tx_OUT,
   output logic       busy_OUT
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state, state_nx;
   logic [BW-1:0] baud, baud_nx;
   logic [2:0]    bit_idx, bit_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          tx_nx, ready_nx, busy_nx;
   logic          last;
   logic [2:0]    bit_inc;

   assign last    = (baud == BAUD_MAX);
   assign bit_inc = bit_idx + 3'd1;

   always_ff @(posedge clock_IN) begin
      if (reset_IN) begin
         state     <= IDLE;
         baud      <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         tx_OUT    <= 1'b1;
         ready_OUT <= 1'b1;
         busy_OUT  <= 1'b0;
      end else begin
         state     <= state_nx;
         baud      <= baud_nx;
         bit_idx   <= bit_nx;
         shreg     <= shreg_nx;
         tx_OUT    <= tx_nx;
         ready_OUT <= ready_nx;
         busy_OUT  <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      baud_nx  = baud;
      bit_nx   = bit_idx;
      shreg_nx = shreg;
      tx_nx    = tx_OUT;
      ready_nx = ready_OUT;
      busy_nx  = busy_OUT;
      if (state != IDLE) begin
         baud_nx = last ? '0 : baud + 1'b1;
      end
      unique case (state)
         IDLE: begin
            baud_nx = '0;
            if (valid_IN && ready_OUT) begin
               state_nx = START;
               shreg_nx = data_IN;
               tx_nx    = 1'b0;
               ready_nx = 1'b0;
               busy_nx  = 1'b1;
            end
         end
         START: begin
            if (last) begin
               state_nx = DATA;
               bit_nx   = 3'd0;
               tx_nx    = shreg[0];
            end
         end
         DATA: begin
            if (last) begin
               if (bit_idx == 3'd7) begin
                  // Even parity bit makes the total count of ones even
                  if (PARITY_EN != 0) begin
                     state_nx = PARITY;
                     tx_nx    = ^shreg;
                  end else begin
                     state_nx = STOP;
                     tx_nx    = 1'b1;
                  end
               end else begin
                  bit_nx = bit_inc;
                  tx_nx  = shreg[bit_inc];
               end
            end
         end
         PARITY: begin
            if (last) begin
               state_nx = STOP;
               tx_nx    = 1'b1;
            end
         end
         STOP: begin
            if (last) begin
               state_nx = IDLE;
               tx_nx    = 1'b1;
               ready_nx = 1'b1;
               busy_nx  = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
            ready_nx = 1'b1;
            busy_nx  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 and 8E1 at 4 clocks/bit plus the
// default 5208 clocks/bit, with a mid-bit sampling receiver model.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic [2:0] valid;
   logic [2:0] ready;
   logic [2:0] tx;
   logic [2:0] busy;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_np (
      .clock_IN (clk),
      .reset_IN (rst),
      .data_IN  (data),
      .valid_IN (valid[0]),
      .ready_OUT(ready[0]),
      .tx_OUT   (tx[0]),
      .busy_OUT (busy[0])
   );

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
      .clock_IN (clk),
      .reset_IN (rst),
      .data_IN  (data),
      .valid_IN (valid[1]),
      .ready_OUT(ready[1]),
      .tx_OUT   (tx[1]),
      .busy_OUT (busy[1])
   );

   uart_tx u_def (
      .clock_IN (clk),
      .reset_IN (rst),
      .data_IN  (data),
      .valid_IN (valid[2]),
      .ready_OUT(ready[2]),
      .tx_OUT   (tx[2]),
      .busy_OUT (busy[2])
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input bit par, input int n);
      if (n == 0) return 1'b0;
      if (n <= 8) return b[n-1];
      if (n == 9 && par) return ^b;
      return 1'b1;
   endfunction

   // Called just after the accept edge; returns just after the edge
   // where the frame completes (ready back high).
   task automatic check_frame(input int u, input logic [7:0] b, input bit par,
                              input int cpb, input string tag);
      int f;
      logic [7:0] rx;
      f  = par ? 11 : 10;
      rx = 8'h00;
      for (int k = 0; k < f * cpb; k++) begin
         int n;
         logic e;
         n = k / cpb;
         e = exp_bit(b, par, n);
         checks++;
         if (tx[u] !== e || ready[u] !== 1'b0 || busy[u] !== 1'b1) begin
            errors++;
            $display("FAIL %s bit %0d clk %0d: tx=%b ready=%b busy=%b, required tx=%b ready=0 busy=1",
                     tag, n, k, tx[u], ready[u], busy[u], e);
         end
         if (k % cpb == cpb / 2 && n >= 1 && n <= 8) rx[n-1] = tx[u];
         step();
      end
      checks++;
      if (tx[u] !== 1'b1 || ready[u] !== 1'b1 || busy[u] !== 1'b0) begin
         errors++;
         $display("FAIL %s end: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
                  tag, tx[u], ready[u], busy[u]);
      end
      checks++;
      if (rx !== b) begin
         errors++;
         $display("FAIL %s loopback: got %h, required %h", tag, rx, b);
      end
   endtask

   task automatic send(input int u, input logic [7:0] b, input string tag);
      checks++;
      if (ready[u] !== 1'b1) begin
         errors++;
         $display("FAIL %s ready before accept: got %b, required 1", tag, ready[u]);
      end
      data     = b;
      valid[u] = 1'b1;
      step();
      valid[u] = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      valid = 3'b111;
      data  = 8'h5A;
      repeat (3) begin
         step();
         checks++;
         if (tx !== 3'b111 || ready !== 3'b111 || busy !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: tx=%b ready=%b busy=%b, required 111 111 000",
                     tx, ready, busy);
         end
      end
      valid = 3'b000;
      rst   = 1'b0;
      step();
      checks++;
      if (tx !== 3'b111 || ready !== 3'b111 || busy !== 3'b000) begin
         errors++;
         $display("FAIL reset_idle: tx=%b ready=%b busy=%b, required 111 111 000",
                  tx, ready, busy);
      end
   endtask

   task automatic test_8n1();
      send(0, 8'h55, "8n1_55");
      check_frame(0, 8'h55, 1'b0, 4, "8n1_55");
      step();
      send(0, 8'hC4, "8n1_c4");
      check_frame(0, 8'hC4, 1'b0, 4, "8n1_c4");
   endtask

   task automatic test_parity();
      send(1, 8'hA3, "par_a3");
      check_frame(1, 8'hA3, 1'b1, 4, "par_a3");
      step();
      send(1, 8'h07, "par_07");
      check_frame(1, 8'h07, 1'b1, 4, "par_07");
   endtask

   task automatic test_back_to_back();
      step();
      data     = 8'h00;
      valid[0] = 1'b1;
      step();
      data = 8'hFF;
      check_frame(0, 8'h00, 1'b0, 4, "b2b_first");
      step();
      valid[0] = 1'b0;
      check_frame(0, 8'hFF, 1'b0, 4, "b2b_second");
   endtask

   task automatic test_reset_mid_frame();
      step();
      send(0, 8'h33, "rst_mid");
      repeat (14) step();
      checks++;
      if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid pre: tx=%b busy=%b, required tx=0 busy=1", tx[0], busy[0]);
      end
      rst = 1'b1;
      step();
      checks++;
      if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid edge: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
                  tx[0], ready[0], busy[0]);
      end
      rst      = 1'b0;
      data     = 8'h0F;
      valid[0] = 1'b1;
      step();
      valid[0] = 1'b0;
      check_frame(0, 8'h0F, 1'b0, 4, "rst_mid_0f");
   endtask

   task automatic test_default_baud();
      send(2, 8'h41, "def_41");
      check_frame(2, 8'h41, 1'b0, 5208, "def_41");
   endtask

   initial begin
      rst   = 1'b1;
      valid = 3'b000;
      data  = 8'h00;
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_reset_mid_frame();
      test_default_baud();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
